// File: rtl/matrix_pkg.sv
// Shared constants, types and index helpers for the matrix word store.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package matrix_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ROWS       = 10;
    localparam int COLS       = 10;
    localparam int ADDR_WIDTH = 4;

    localparam int DEPTH     = ROWS * COLS;
    localparam int IDX_WIDTH = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DUMP = 2'd2
    } store_state_t;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [IDX_WIDTH-1:0]  idx_t;

    localparam addr_t ROW_LAST = addr_t'(ROWS - 1);
    localparam addr_t COL_LAST = addr_t'(COLS - 1);

    // Compare with one spare bit so a ROWS/COLS equal to 2**ADDR_WIDTH still works.
    function automatic logic in_range(input addr_t row, input addr_t col);
        return ({1'b0, row} < (ADDR_WIDTH + 1)'(ROWS)) &&
               ({1'b0, col} < (ADDR_WIDTH + 1)'(COLS));
    endfunction

    // Row-major linear index; only meaningful when in_range() holds.
    function automatic idx_t lin_idx(input addr_t row, input addr_t col);
        return idx_t'(int'(row) * COLS + int'(col));
    endfunction

endpackage

// File: rtl/matrix_store_if.sv
// Bundle of engine strobes, host load/dump streams and status for one matrix store.
// Latency: wires only.
// Backpressure: s_ready throttles the load stream, m_ready throttles the dump stream.
interface matrix_store_if;
    import matrix_pkg::*;

    // engine port
    logic  en_read;
    logic  en_write;
    addr_t row_addr;
    addr_t col_addr;
    word_t wr_data;
    word_t rd_data;
    logic  rd_valid;

    // host control
    logic  load_start;
    logic  dump_start;

    // host load stream
    logic  s_valid;
    logic  s_ready;
    word_t s_data;

    // host dump stream
    logic  m_valid;
    logic  m_ready;
    word_t m_data;

    // status
    logic  busy;
    logic  done;
    logic  addr_err;

    modport master (
        output en_read, en_write, row_addr, col_addr, wr_data,
        output load_start, dump_start,
        output s_valid, s_data, m_ready,
        input  rd_data, rd_valid, s_ready, m_valid, m_data,
        input  busy, done, addr_err
    );

    modport slave (
        input  en_read, en_write, row_addr, col_addr, wr_data,
        input  load_start, dump_start,
        input  s_valid, s_data, m_ready,
        output rd_data, rd_valid, s_ready, m_valid, m_data,
        output busy, done, addr_err
    );

endinterface

// File: rtl/matrix_addr_counter.sv
// Row-major (row, col) walker shared by the host load and dump paths.
// Latency: advance/clear take effect on the next rising edge; last is combinational.
// Backpressure: none; the caller only pulses advance when an element moves.
module matrix_addr_counter
    import matrix_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  clear,
    input  logic  advance,
    output addr_t row,
    output addr_t col,
    output logic  last
);

    assign last = (row == ROW_LAST) && (col == COL_LAST);

    // Column wraps into the next row; the final element wraps back to the origin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= last ? '0 : row + addr_t'(1);
            end else begin
                col <= col + addr_t'(1);
            end
        end
    end

endmodule

// File: rtl/matrix_store.sv
// ROWS x COLS word store: engine random access plus host bulk load/dump streams.
// Latency: engine read 1 cycle; one load word accepted per cycle; dump issues one word per cycle.
// Backpressure: any engine strobe stalls the host port that cycle; dump holds m_data/m_valid while !m_ready.
module matrix_store
    import matrix_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    matrix_store_if.slave  bus
);

    store_state_t state;
    store_state_t state_nxt;

    word_t mem [DEPTH];

    addr_t cnt_row;
    addr_t cnt_col;
    logic  cnt_last;
    logic  cnt_clear;
    logic  cnt_adv;

    logic  eng_access;
    logic  eng_ok;
    idx_t  eng_idx;
    idx_t  host_idx;

    logic  s_ready_c;
    logic  load_acc;
    logic  dump_issue;
    logic  dump_hs;
    logic  issued_all;
    logic  done_nxt;

    logic  m_valid_q;
    word_t m_data_q;
    word_t rd_data_q;
    logic  rd_valid_q;
    logic  addr_err_q;
    logic  done_q;

    assign eng_access = bus.en_read || bus.en_write;
    assign eng_ok     = in_range(bus.row_addr, bus.col_addr);
    assign eng_idx    = lin_idx(bus.row_addr, bus.col_addr);
    assign host_idx   = lin_idx(cnt_row, cnt_col);
    assign dump_hs    = m_valid_q && bus.m_ready;
    assign cnt_adv    = load_acc || dump_issue;

    matrix_addr_counter u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .advance (cnt_adv),
        .row     (cnt_row),
        .col     (cnt_col),
        .last    (cnt_last)
    );

    // State register for the host transfer FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, host handshakes and completion; engine traffic always wins the cycle.
    always_comb begin
        state_nxt  = state;
        done_nxt   = 1'b0;
        cnt_clear  = 1'b0;
        s_ready_c  = 1'b0;
        load_acc   = 1'b0;
        dump_issue = 1'b0;
        case (state)
            IDLE: begin
                cnt_clear = 1'b1;
                if (bus.load_start) begin
                    state_nxt = LOAD;
                end else if (bus.dump_start) begin
                    state_nxt = DUMP;
                end
            end
            LOAD: begin
                s_ready_c = !eng_access;
                load_acc  = bus.s_valid && s_ready_c;
                if (load_acc && cnt_last) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            DUMP: begin
                dump_issue = (!m_valid_q || bus.m_ready) && !eng_access && !issued_all;
                if (dump_hs && issued_all) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Completion pulse lands the cycle after the final handshake, alongside the return to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_nxt;
        end
    end

    // Word array is deliberately unreset so an aborted load keeps what already landed.
    always_ff @(posedge clk) begin
        if (bus.en_write && eng_ok) begin
            mem[eng_idx] <= bus.wr_data;
        end else if (load_acc) begin
            mem[host_idx] <= bus.s_data;
        end
    end

    // Engine read path: nonblocking read gives the pre-write value on a same-cycle write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.en_read;
            if (bus.en_read) begin
                rd_data_q <= eng_ok ? mem[eng_idx] : '0;
            end
            if (eng_access && !eng_ok) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    // Dump output register: data is fetched at issue time, so late engine writes are picked up.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            issued_all <= 1'b0;
        end else begin
            if (dump_issue) begin
                m_valid_q <= 1'b1;
                m_data_q  <= mem[host_idx];
            end else if (dump_hs) begin
                m_valid_q <= 1'b0;
            end
            if (state == IDLE) begin
                issued_all <= 1'b0;
            end else if (dump_issue && cnt_last) begin
                issued_all <= 1'b1;
            end
        end
    end

    assign bus.s_ready  = s_ready_c;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_data   = m_data_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.addr_err = addr_err_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_matrix_store.sv
// Directed bench for matrix_store with queued expectations and a decoupled output monitor.
// Latency: engine reads expected one cycle after the strobe; dump words at each handshake.
// Backpressure: drives m_ready patterns and engine strobes to exercise stalls.
module tb_matrix_store;
    import matrix_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    matrix_store_if bus();

    matrix_store dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int    checks = 0;
    int    errors = 0;
    int    done_cnt = 0;
    word_t exp_rd[$];
    word_t exp_dump[$];
    word_t model [DEPTH];
    logic  hold_pend = 1'b0;
    word_t hold_dat = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every read return and dump handshake against the queued expectations.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.done) done_cnt++;
            if (bus.rd_valid) begin
                check("rd_expected", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) check("rd_data", bus.rd_data, exp_rd.pop_front());
            end
            if (hold_pend) begin
                check("m_valid_hold", bus.m_valid, 1);
                check("m_data_hold", bus.m_data, hold_dat);
            end
            if (bus.m_valid && bus.m_ready) begin
                check("dump_expected", exp_dump.size() != 0, 1);
                if (exp_dump.size() != 0) check("m_data", bus.m_data, exp_dump.pop_front());
            end
            hold_pend = bus.m_valid && !bus.m_ready;
            hold_dat  = bus.m_data;
        end else begin
            hold_pend = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One engine cycle; expected read value is taken from the model before any write lands.
    task automatic eng(input bit rd, input bit wr, input int r, input int c, input word_t wd);
        bit ok;
        ok = (r < ROWS) && (c < COLS);
        bus.en_read  = rd;
        bus.en_write = wr;
        bus.row_addr = addr_t'(r);
        bus.col_addr = addr_t'(c);
        bus.wr_data  = wd;
        if (rd) exp_rd.push_back(ok ? model[r * COLS + c] : word_t'(0));
        if (wr && ok) model[r * COLS + c] = wd;
        tick();
        if (rd) check("rd_valid_pulse", bus.rd_valid, 1);
        bus.en_read  = 1'b0;
        bus.en_write = 1'b0;
    endtask

    task automatic load_run(input int base, input bit stall, input int abort_at, output int cycles);
        int idx;
        bit seen;
        bit rd;
        bit acc;
        idx = 0;
        seen = 1'b0;
        cycles = 0;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        while (!seen && cycles < 400) begin
            if (abort_at >= 0 && idx == abort_at) break;
            bus.s_valid  = (idx < DEPTH);
            bus.s_data   = word_t'(base + idx);
            rd = stall && (cycles < 100) && (cycles % 2 == 0);
            bus.en_read  = rd;
            bus.row_addr = addr_t'(ROWS - 1);
            bus.col_addr = addr_t'(COLS - 1);
            if (rd) exp_rd.push_back(model[DEPTH - 1]);
            acc = 1'b0;
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                check("busy_at_done", bus.busy, 0);
            end else begin
                if (cycles == 0) check("busy_in_load", bus.busy, 1);
                check("s_ready", bus.s_ready, !rd);
                acc = bus.s_valid && bus.s_ready;
            end
            tick();
            if (acc) begin
                model[idx] = word_t'(base + idx);
                idx++;
            end
            if (!seen) cycles++;
        end
        bus.en_read = 1'b0;
        if (abort_at >= 0) begin
            reset_n = 1'b0;
            #1;
            check("abort_busy", bus.busy, 0);
            check("abort_s_ready", bus.s_ready, 0);
            check("abort_done", bus.done, 0);
            check("abort_rd_data", bus.rd_data, 0);
            check("abort_addr_err", bus.addr_err, 0);
            bus.s_valid = 1'b0;
            tick();
            reset_n = 1'b1;
        end else begin
            bus.s_valid = 1'b0;
            check("load_done_seen", seen, 1);
        end
    endtask

    task automatic dump_run(input bit toggle, output int cycles);
        bit seen;
        seen = 1'b0;
        cycles = 0;
        for (int i = 0; i < DEPTH; i++) exp_dump.push_back(model[i]);
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        while (!seen && cycles < 600) begin
            bus.m_ready = toggle ? (cycles % 2 == 0) : 1'b1;
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                check("busy_at_dump_done", bus.busy, 0);
            end
            tick();
            if (!seen) cycles++;
        end
        bus.m_ready = 1'b0;
        check("dump_done_seen", seen, 1);
        check("dump_all_drained", exp_dump.size(), 0);
    endtask

    initial begin
        int cyc;
        int d0;
        bus.en_read = 0; bus.en_write = 0; bus.row_addr = '0; bus.col_addr = '0;
        bus.wr_data = '0; bus.load_start = 0; bus.dump_start = 0;
        bus.s_valid = 0; bus.s_data = '0; bus.m_ready = 0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        repeat (2) tick();
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_addr_err", bus.addr_err, 0);
        reset_n = 1'b1;
        tick();

        // full load 0..99 with s_valid held high
        d0 = done_cnt;
        load_run(0, 1'b0, -1, cyc);
        check("load_cycles", cyc, DEPTH);
        repeat (2) tick();
        check("load_done_once", done_cnt - d0, 1);
        eng(1, 0, 3, 7, '0);
        tick();

        // dump with m_ready toggling 1,0,1,0
        d0 = done_cnt;
        dump_run(1'b1, cyc);
        check("dump_toggle_cycles", cyc, 2 * DEPTH + 1);
        repeat (2) tick();
        check("dump_done_once", done_cnt - d0, 1);

        // simultaneous write+read returns old value, next read returns new
        eng(1, 1, 2, 5, 16'hBEEF);
        eng(1, 0, 2, 5, '0);
        tick();

        // out-of-range engine accesses
        check("addr_err_clear", bus.addr_err, 0);
        eng(1, 0, 10, 0, '0);
        check("addr_err_set", bus.addr_err, 1);
        eng(0, 1, 0, 12, 16'h1234);
        eng(1, 0, 1, 2, '0);
        repeat (3) tick();
        check("addr_err_sticky", bus.addr_err, 1);

        // load with engine reads every other cycle for the first 100 cycles
        d0 = done_cnt;
        load_run(1000, 1'b1, -1, cyc);
        check("stall_load_cycles", cyc, DEPTH + 50);
        repeat (2) tick();
        check("stall_done_once", done_cnt - d0, 1);
        eng(1, 0, 3, 7, '0);
        eng(1, 0, 9, 9, '0);
        tick();

        // reset at element 40 of a load, then dump the mixed contents
        d0 = done_cnt;
        load_run(2000, 1'b0, 40, cyc);
        repeat (3) tick();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_addr_err_after", bus.addr_err, 0);
        dump_run(1'b0, cyc);
        check("dump_cycles", cyc, DEPTH + 1);
        repeat (2) tick();
        check("rd_queue_drained", exp_rd.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_store.md
# matrix_store

Responder side of the matrix-multiplier memory interface: one ROWS×COLS word store, instantiated once each for matrices A, B and C. It services the compute controller's row/column read and write strobes. It also provides a host streaming port that bulk-loads a whole matrix in row-major order (A/B) or dumps one (C) while the engine is idle.

## Interface
- DATA_WIDTH, 16, word width
- ROWS, 10, matrix rows
- COLS, 10, matrix columns
- ADDR_WIDTH, 4, row/column address width
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- en_read  in  1  engine read strobe
- en_write  in  1  engine write strobe
- row_addr  in  ADDR_WIDTH  engine row address
- col_addr  in  ADDR_WIDTH  engine column address
- wr_data  in  DATA_WIDTH  engine write data
- rd_data  out  DATA_WIDTH  engine read data, registered
- rd_valid  out  1  engine read data valid pulse
- load_start  in  1  begin host load (pulse)
- dump_start  in  1  begin host dump (pulse)
- s_valid / s_ready / s_data  in / out / in  1/1/DATA_WIDTH  host load stream
- m_valid / m_ready / m_data  out / in / out  1/1/DATA_WIDTH  host dump stream
- busy  out  1  load or dump in progress
- done  out  1  one-cycle pulse when load/dump completes
- addr_err  out  1  sticky out-of-range engine access flag

## Operation
- Storage: ROWS*COLS words, linear index row*COLS+col; contents are not reset.
- Engine write: mem[row][col] <= wr_data at the edge where en_write=1.
- Engine read: rd_data <= mem[row][col], rd_valid=1 the next cycle. rd_data holds its value until the next read.
- en_read and en_write together: the write is performed and the read returns the pre-write value.
- Out-of-range address (row>=ROWS or col>=COLS): the write is dropped and a read returns 0 with rd_valid still pulsing. addr_err is set and cleared only by reset.
- FSM states IDLE, LOAD, DUMP.
  - IDLE→LOAD on load_start. IDLE→DUMP on dump_start.
  - Both asserted together: LOAD wins.
  - Starts are ignored outside IDLE.
- Host counters r,c start at 0,0. c wraps COLS-1→0 and increments r.
- Engine priority: any en_read/en_write cycle stalls the host port in that cycle.
- LOAD:
  - s_ready = (state==LOAD) && !en_read && !en_write.
  - Each s_valid&&s_ready writes mem[r][c] and advances the counters.
  - Acceptance of element (ROWS-1,COLS-1) → IDLE and a done pulse.
- DUMP:
  - Issue condition: (!m_valid || m_ready), no engine access, and elements remain.
  - On issue: m_data <= mem[r][c], m_valid <= 1, counters advance.
  - m_valid drops on m_valid&&m_ready with no new issue.
  - Handshake of the last element → IDLE and a done pulse.
  - m_data/m_valid are stable while m_valid&&!m_ready.
- An engine write during DUMP to a not-yet-issued element is dumped with the new value.

## Timing
- Reset values: rd_data=0, rd_valid=0, s_ready=0, m_valid=0, m_data=0, busy=0, done=0, addr_err=0, state=IDLE, r=c=0.
- Engine read latency is 1 cycle; engine write is visible to a read issued in the next cycle.
- busy=1 from the cycle after the start pulse until the cycle done pulses. done is asserted the cycle after the final handshake, and busy=0 in that same cycle.
- Full load with s_valid held high and no engine traffic: ROWS*COLS cycles (100 at defaults).
- Full dump with m_ready held high: ROWS*COLS+1 cycles from the first issue to the final handshake.
- Reset mid-load or mid-dump: abort immediately with all outputs at reset values. Already-written words are retained; no done pulse.

## Structure
- Package matrix_pkg holds:
  - constants DATA_WIDTH, ROWS, COLS, ADDR_WIDTH;
  - typedef enum store_state_t {IDLE, LOAD, DUMP};
  - typedef logic [DATA_WIDTH-1:0] word_t.
- Sub-module matrix_addr_counter: wrapping row/column counter with clear, advance and last outputs, reused by the LOAD and DUMP paths.

## Test plan
- Load 0..99 via the stream with s_valid held high → 100 cycles, done pulses once, engine reads of (3,7) return 37 one cycle later.
- Engine write (2,5)=0xBEEF with a simultaneous read of (2,5) → rd_data returns the old value; a read the next cycle returns 0xBEEF.
- Dump with m_ready toggling 1,0,1,0 → stream is 0..99 in order with no duplicates, and m_data holds while stalled.
- en_read asserted every other cycle during LOAD → s_ready=0 on those cycles, all 100 words still land, done is delayed by 50 cycles.
- Read (10,0) and write (0,12) → rd_data=0, rd_valid pulses, memory is unchanged, addr_err=1 and stays set.
- reset_n low at element 40 of a load → outputs reset, no done; a subsequent dump shows elements 0..39 loaded.
